// File: rtl/pc_sequencer.sv
// LEGv8 fetch/PC controller: owns the PC, fetches over req/ack, issues instructions, selects next PC.
// Optional retire/taken performance counters are compiled in with PC_SEQ_PERF_CNT_EN.
module pc_sequencer #(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int unsigned IMEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        cond_true,
    output logic [63:0] pc,
`ifdef PC_SEQ_PERF_CNT_EN
    output logic        fault,
    output logic [31:0] retired_cnt,
    output logic [31:0] taken_cnt
`else
    output logic        fault
`endif
);

    localparam int unsigned XLEN   = 64;
    localparam int unsigned ILEN   = 32;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(IMEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_nxt;
    logic [ILEN-1:0]   r_instr;
    logic [ILEN-1:0]   w_instr_nxt;
    logic [CNT_W-1:0]  r_to_cnt;
    logic [CNT_W-1:0]  w_to_cnt_nxt;
    logic              r_imem_req;
    logic              r_instr_valid;
    logic              r_fault;
    logic              w_retire;

    // Branch decode and word-aligned, sign-extended offsets of the issued instruction
    logic              w_is_b;
    logic              w_is_cb;
    logic [XLEN-1:0]   w_b_off;
    logic [XLEN-1:0]   w_cb_off;

    assign w_is_b   = (r_instr[31:26] == 6'b000101);
    assign w_is_cb  = (r_instr[31:25] == 7'b1011010);
    assign w_b_off  = {{36{r_instr[25]}}, r_instr[25:0], 2'b00};
    assign w_cb_off = {{43{r_instr[23]}}, r_instr[23:5], 2'b00};

    // Next-state, next-PC and timeout sequencing
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_to_cnt_nxt = r_to_cnt;
        w_retire     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_instr_nxt  = imem_data;
                    w_to_cnt_nxt = '0;
                    w_state_nxt  = S_ISSUE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt  = S_FAULT;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
                    if (w_is_b) begin
                        w_pc_nxt = r_pc + w_b_off;
                    end else if (w_is_cb && cond_true) begin
                        w_pc_nxt = r_pc + w_cb_off;
                    end else begin
                        w_pc_nxt = r_pc + XLEN'(4);
                    end
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register with outputs registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_to_cnt      <= '0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
            r_imem_req    <= (w_state_nxt == S_FETCH);
            r_instr_valid <= (w_state_nxt == S_ISSUE);
            r_fault       <= (w_state_nxt == S_FAULT);
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign fault       = r_fault;

`ifdef PC_SEQ_PERF_CNT_EN
    localparam int unsigned PERF_W = 32;

    logic [PERF_W-1:0] r_retired_cnt;
    logic [PERF_W-1:0] r_taken_cnt;
    logic              w_taken;

    assign w_taken = w_is_b | (w_is_cb & cond_true);

    // Retire counters only move on retire cycles, so they hold in FAULT
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired_cnt <= '0;
            r_taken_cnt   <= '0;
        end else if (w_retire) begin
            r_retired_cnt <= r_retired_cnt + PERF_W'(1);
            if (w_taken) begin
                r_taken_cnt <= r_taken_cnt + PERF_W'(1);
            end
        end
    end

    assign retired_cnt = r_retired_cnt;
    assign taken_cnt   = r_taken_cnt;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: an architectural next-PC model plus a per-cycle compare process.
module tb_pc_sequencer;

    localparam logic [63:0] RST_PC = 64'h0;
    localparam int unsigned TO     = 4;
    localparam logic [31:0] ADD    = 32'h8B020020;
    localparam logic [31:0] JUNK   = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        cond_true = 1'b0;
    logic [63:0] pc;
    logic        fault;
`ifdef PC_SEQ_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] taken_cnt;
`endif

    pc_sequencer #(.RESET_PC(RST_PC), .IMEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .cond_true(cond_true),
        .pc(pc),
`ifdef PC_SEQ_PERF_CNT_EN
        .fault(fault), .retired_cnt(retired_cnt), .taken_cnt(taken_cnt)
`else
        .fault(fault)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected observable state for the current cycle
    logic        m_chk = 1'b0;
    logic        m_rst = 1'b0;
    logic        m_req = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = 32'h0;
    logic [63:0] m_pc = 64'h0;
    logic        m_fault = 1'b0;
    int unsigned m_ret = 0;
    int unsigned m_tak = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_taken(input logic [31:0] ins, input logic c);
        logic [5:0] op6;
        logic [6:0] op7;
        op6 = ins[31:26];
        op7 = ins[31:25];
        return (op6 == 6'd5) || ((op7 == 7'h5A) && c);
    endfunction

    function automatic logic [63:0] model_next(input logic [63:0] p, input logic [31:0] ins,
                                               input logic c);
        logic [25:0] imm26;
        logic [18:0] imm19;
        longint      off;
        logic [5:0]  op6;
        imm26 = ins[25:0];
        imm19 = ins[23:5];
        op6   = ins[31:26];
        if (op6 == 6'd5)             off = longint'($signed(imm26)) * 4;
        else if (model_taken(ins, c)) off = longint'($signed(imm19)) * 4;
        else                          off = 4;
        return p + 64'(off);
    endfunction

    // Per-cycle compare, sampled mid-cycle away from the active edge
    always @(negedge clk) begin
        if (m_chk) begin
            check("imem_req", 64'(imem_req), 64'(m_req));
            check("instr_valid", 64'(instr_valid), 64'(m_valid));
            check("pc", pc, m_pc);
            check("fault", 64'(fault), 64'(m_fault));
            check("req_valid_exclusive", 64'(imem_req & instr_valid), 64'(0));
            if (m_req) check("imem_addr", imem_addr, m_pc);
            if (m_valid || m_rst) check("instr", 64'(instr), 64'(m_instr));
`ifdef PC_SEQ_PERF_CNT_EN
            check("retired_cnt", 64'(retired_cnt), 64'(m_ret));
            check("taken_cnt", 64'(taken_cnt), 64'(m_tak));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of the first FETCH cycle after reset
    task automatic do_reset();
        reset = 1'b1;
        step();
        imem_ack  = 1'b0;
        stall     = 1'b0;
        cond_true = 1'b0;
        m_chk = 1'b1; m_rst = 1'b1; m_req = 1'b0; m_valid = 1'b0; m_instr = 32'h0;
        m_pc = RST_PC; m_fault = 1'b0; m_ret = 0; m_tak = 0;
        step();
        reset = 1'b0;
        step();
        m_req = 1'b1;
        m_rst = 1'b0;
    endtask

    // One fetch/issue/retire; entered and left in a FETCH cycle
    task automatic run(input logic [31:0] d, input int aw, input int sn, input logic c,
                       input logic [63:0] exp_pc);
        stall    = (sn > 0);
        imem_ack = 1'b0;
        repeat (aw) step();
        imem_ack  = 1'b1;
        imem_data = d;
        step();
        m_req = 1'b0; m_valid = 1'b1; m_instr = d;
        imem_data = JUNK;
        for (int i = 0; i < sn; i++) begin
            stall     = 1'b1;
            imem_ack  = 1'b1;
            cond_true = ~c;
            step();
        end
        stall     = 1'b0;
        imem_ack  = 1'b0;
        cond_true = c;
        step();
        cond_true = 1'b0;
        m_ret++;
        if (model_taken(d, c)) m_tak++;
        m_pc  = model_next(m_pc, d, c);
        m_req = 1'b1; m_valid = 1'b0;
        check("pc_literal", pc, exp_pc);
    endtask

    initial begin
        do_reset();

        // Sequential fetch
        run(ADD, 0, 0, 1'b0, 64'h4);
        run(ADD, 0, 0, 1'b0, 64'h8);
        run(ADD, 0, 0, 1'b0, 64'hC);
`ifdef PC_SEQ_PERF_CNT_EN
        check("retired_literal", 64'(retired_cnt), 64'd3);
        check("taken_literal", 64'(taken_cnt), 64'd0);
`endif

        // Wrap-around in both directions
        do_reset();
        run(32'h17FFFFFF, 0, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
        run(ADD, 0, 0, 1'b0, 64'h0);

        // B forward/backward and CB taken/not-taken
        run(32'h14000040, 0, 0, 1'b0, 64'h100);
        run(32'h17FFFFFF, 0, 0, 1'b0, 64'hFC);
        run(32'h14000001, 0, 0, 1'b0, 64'h100);
        run(32'h14000010, 0, 0, 1'b0, 64'h140);
        run(32'h14000030, 0, 0, 1'b0, 64'h200);
        run(32'hB4000080, 0, 0, 1'b1, 64'h210);
        run(32'h17FFFFFC, 0, 0, 1'b0, 64'h200);
        run(32'hB4000080, 0, 0, 1'b0, 64'h204);
        run(32'hB5FFFFE0, 0, 0, 1'b1, 64'h200);
        run(32'h54000000, 0, 0, 1'b1, 64'h204);

        // Stall for five cycles with stray acks, then a late ack on the last allowed cycle
        run(ADD, 1, 5, 1'b0, 64'h208);
        run(ADD, 3, 0, 1'b0, 64'h20C);
        check("no_fault_literal", 64'(fault), 64'd0);

        // Timeout: no ack for TO cycles
        imem_ack = 1'b0;
        repeat (TO) step();
        m_req = 1'b0; m_fault = 1'b1;
        imem_ack = 1'b1; stall = 1'b1;
        repeat (3) step();
        check("fault_literal", 64'(fault), 64'd1);
        check("fault_req_literal", 64'(imem_req), 64'd0);
        imem_ack = 1'b0; stall = 1'b0;

        do_reset();
        check("reset_fault_literal", 64'(fault), 64'd0);
        check("reset_pc_literal", pc, RST_PC);

        // Reset in FETCH with a simultaneous ack
        run(ADD, 0, 0, 1'b0, 64'h4);
        imem_ack  = 1'b1;
        imem_data = ADD;
        do_reset();
        check("midfetch_pc_literal", pc, RST_PC);

        // Reset during a stalled ISSUE
        imem_ack  = 1'b1;
        imem_data = 32'h14000040;
        step();
        m_req = 1'b0; m_valid = 1'b1; m_instr = 32'h14000040;
        imem_ack = 1'b0;
        stall    = 1'b1;
        step();
        do_reset();
        check("issue_reset_pc_literal", pc, RST_PC);
        run(ADD, 0, 0, 1'b0, 64'h4);

        m_chk = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
